// File: rtl/mem_pkg.sv
// Shared definitions for the memory-access pipeline stage: load-op encodings,
// FSM state encoding and the default reset PC.
package mem_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h1c00_0000;

    typedef enum logic [2:0] {
        LD_NONE = 3'd0,
        LD_B    = 3'd1,
        LD_H    = 3'd2,
        LD_W    = 3'd3,
        LD_BU   = 3'd4,
        LD_HU   = 3'd5
    } load_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } ms_state_e;

    // Sign- or zero-extend a byte/halfword into a 32-bit word.
    function automatic logic [31:0] ext8(input logic [7:0] b, input logic sx);
        return {{24{sx & b[7]}}, b};
    endfunction

    function automatic logic [31:0] ext16(input logic [15:0] h, input logic sx);
        return {{16{sx & h[15]}}, h};
    endfunction

endpackage

// File: rtl/load_align.sv
// Extracts and extends the loaded byte/halfword/word from the raw read data.
module load_align
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [2:0]  load_op,
    output logic [31:0] data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane select, then extension by load type.
    always_comb begin
        byte_s = 8'h00;
        case (addr)
            2'd0:    byte_s = rdata[7:0];
            2'd1:    byte_s = rdata[15:8];
            2'd2:    byte_s = rdata[23:16];
            2'd3:    byte_s = rdata[31:24];
            default: byte_s = 8'h00;
        endcase
        if (addr[1]) begin
            half_s = rdata[31:16];
        end else begin
            half_s = rdata[15:0];
        end
        case (load_op)
            LD_B:    data = ext8(byte_s, 1'b1);
            LD_BU:   data = ext8(byte_s, 1'b0);
            LD_H:    data = ext16(half_s, 1'b1);
            LD_HU:   data = ext16(half_s, 1'b0);
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: holds one instruction, issues its data-SRAM
// request/response handshake and hands the writeback payload to WB.
module mem_stage
    import mem_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        es_to_ms_valid,
    input  logic [31:0] es_pc,
    input  logic        es_mem_en,
    input  logic [3:0]  es_mem_we,
    input  logic [31:0] es_mem_addr,
    input  logic [31:0] es_mem_wdata,
    input  logic [2:0]  es_load_op,
    input  logic [3:0]  es_rf_we,
    input  logic [4:0]  es_rf_waddr,
    input  logic [31:0] es_rf_wdata,
    output logic        ms_allow_in,
    output logic        data_sram_req,
    output logic        data_sram_wr,
    output logic [3:0]  data_sram_wstrb,
    output logic [31:0] data_sram_addr,
    output logic [31:0] data_sram_wdata,
    input  logic        data_sram_addr_ok,
    input  logic        data_sram_data_ok,
    input  logic [31:0] data_sram_rdata,
    output logic [3:0]  ms_rf_we,
    output logic [4:0]  ms_rf_waddr,
    output logic [31:0] ms_rf_wdata,
    output logic        ms_load_pending,
    input  logic        ws_allow_in,
    output logic        ms_to_ws_valid,
    output logic [31:0] ms_pc_out,
    output logic [3:0]  ms_to_ws_rf_we,
    output logic [4:0]  ms_to_ws_rf_waddr,
    output logic [31:0] ms_to_ws_rf_wdata
);

    ms_state_e   state_q;
    logic        ms_valid_q;
    logic [31:0] pc_q;
    logic        mem_en_q;
    logic [3:0]  mem_we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [2:0]  load_op_q;
    logic [3:0]  rf_we_q;
    logic [4:0]  rf_waddr_q;
    logic [31:0] rf_wdata_q;
    logic [31:0] rdata_q;

    logic        ms_ready_go_s;
    logic [31:0] load_data_s;
    logic [31:0] wb_data_s;

    assign ms_ready_go_s  = (state_q == S_DONE);
    assign ms_allow_in    = !ms_valid_q || (ms_ready_go_s && ws_allow_in);
    assign ms_to_ws_valid = ms_valid_q && ms_ready_go_s;

    // Gated by reset so a pending request drops in the very cycle reset rises.
    assign data_sram_req   = (state_q == S_REQ) && mem_en_q && !reset;
    assign data_sram_wr    = |mem_we_q;
    assign data_sram_wstrb = mem_we_q;
    assign data_sram_addr  = addr_q;
    assign data_sram_wdata = wdata_q;

    load_align u_load_align (
        .rdata   (rdata_q),
        .addr    (addr_q[1:0]),
        .load_op (load_op_q),
        .data    (load_data_s)
    );

    assign wb_data_s = (load_op_q != LD_NONE) ? load_data_s : rf_wdata_q;

    assign ms_rf_we        = ms_valid_q ? rf_we_q : 4'h0;
    assign ms_rf_waddr     = rf_waddr_q;
    assign ms_rf_wdata     = wb_data_s;
    assign ms_load_pending = ms_valid_q && (load_op_q != LD_NONE) && (state_q != S_DONE);

    assign ms_pc_out         = pc_q;
    assign ms_to_ws_rf_we    = rf_we_q;
    assign ms_to_ws_rf_waddr = rf_waddr_q;
    assign ms_to_ws_rf_wdata = wb_data_s;

    // Stage FSM plus payload capture; a capture always overrides the current state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            ms_valid_q <= 1'b0;
            pc_q       <= RESET_PC;
            mem_en_q   <= 1'b0;
            mem_we_q   <= 4'h0;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            load_op_q  <= 3'd0;
            rf_we_q    <= 4'h0;
            rf_waddr_q <= 5'd0;
            rf_wdata_q <= 32'h0;
            rdata_q    <= 32'h0;
        end else if (ms_allow_in) begin
            ms_valid_q <= es_to_ms_valid;
            if (es_to_ms_valid) begin
                pc_q       <= es_pc;
                mem_en_q   <= es_mem_en;
                mem_we_q   <= es_mem_we;
                addr_q     <= es_mem_addr;
                wdata_q    <= es_mem_wdata;
                load_op_q  <= es_load_op;
                rf_we_q    <= es_rf_we;
                rf_waddr_q <= es_rf_waddr;
                rf_wdata_q <= es_rf_wdata;
                state_q    <= es_mem_en ? S_REQ : S_DONE;
            end else begin
                state_q <= S_IDLE;
            end
        end else begin
            case (state_q)
                S_REQ: begin
                    if (data_sram_addr_ok) begin
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (data_sram_data_ok) begin
                        rdata_q <= data_sram_rdata;
                        state_q <= S_DONE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed scoreboard bench for mem_stage: expected WB payloads are queued at
// issue and compared when the stage hands them to WB.
module tb_mem_stage;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        es_to_ms_valid;
    logic [31:0] es_pc;
    logic        es_mem_en;
    logic [3:0]  es_mem_we;
    logic [31:0] es_mem_addr;
    logic [31:0] es_mem_wdata;
    logic [2:0]  es_load_op;
    logic [3:0]  es_rf_we;
    logic [4:0]  es_rf_waddr;
    logic [31:0] es_rf_wdata;
    logic        ms_allow_in;
    logic        data_sram_req;
    logic        data_sram_wr;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic        data_sram_addr_ok;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic [3:0]  ms_rf_we;
    logic [4:0]  ms_rf_waddr;
    logic [31:0] ms_rf_wdata;
    logic        ms_load_pending;
    logic        ws_allow_in;
    logic        ms_to_ws_valid;
    logic [31:0] ms_pc_out;
    logic [3:0]  ms_to_ws_rf_we;
    logic [4:0]  ms_to_ws_rf_waddr;
    logic [31:0] ms_to_ws_rf_wdata;

    typedef struct packed {
        logic [31:0] pc;
        logic [3:0]  we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } wb_t;

    wb_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk               (clk),
        .reset             (reset),
        .es_to_ms_valid    (es_to_ms_valid),
        .es_pc             (es_pc),
        .es_mem_en         (es_mem_en),
        .es_mem_we         (es_mem_we),
        .es_mem_addr       (es_mem_addr),
        .es_mem_wdata      (es_mem_wdata),
        .es_load_op        (es_load_op),
        .es_rf_we          (es_rf_we),
        .es_rf_waddr       (es_rf_waddr),
        .es_rf_wdata       (es_rf_wdata),
        .ms_allow_in       (ms_allow_in),
        .data_sram_req     (data_sram_req),
        .data_sram_wr      (data_sram_wr),
        .data_sram_wstrb   (data_sram_wstrb),
        .data_sram_addr    (data_sram_addr),
        .data_sram_wdata   (data_sram_wdata),
        .data_sram_addr_ok (data_sram_addr_ok),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .ms_rf_we          (ms_rf_we),
        .ms_rf_waddr       (ms_rf_waddr),
        .ms_rf_wdata       (ms_rf_wdata),
        .ms_load_pending   (ms_load_pending),
        .ws_allow_in       (ws_allow_in),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_pc_out         (ms_pc_out),
        .ms_to_ws_rf_we    (ms_to_ws_rf_we),
        .ms_to_ws_rf_waddr (ms_to_ws_rf_waddr),
        .ms_to_ws_rf_wdata (ms_to_ws_rf_wdata)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] pc, input logic men, input logic [3:0] mwe,
                         input logic [31:0] addr, input logic [31:0] mwdata,
                         input logic [2:0] lop, input logic [3:0] rwe,
                         input logic [4:0] rwa, input logic [31:0] rwd);
        es_to_ms_valid = 1'b1;
        es_pc          = pc;
        es_mem_en      = men;
        es_mem_we      = mwe;
        es_mem_addr    = addr;
        es_mem_wdata   = mwdata;
        es_load_op     = lop;
        es_rf_we       = rwe;
        es_rf_waddr    = rwa;
        es_rf_wdata    = rwd;
    endtask

    task automatic push(input logic [31:0] pc, input logic [3:0] we,
                        input logic [4:0] wa, input logic [31:0] wd);
        wb_t e;
        e.pc = pc; e.we = we; e.waddr = wa; e.wdata = wd;
        exp_q.push_back(e);
    endtask

    // Compare the payload currently offered to WB against the oldest expectation.
    task automatic sb_check(input string tag);
        wb_t e;
        chk({tag, ".valid"}, {31'd0, ms_to_ws_valid}, 32'd1);
        if (exp_q.size() == 0) begin
            chk({tag, ".sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk({tag, ".pc"},    ms_pc_out,                  e.pc);
            chk({tag, ".we"},    {28'd0, ms_to_ws_rf_we},    {28'd0, e.we});
            chk({tag, ".waddr"}, {27'd0, ms_to_ws_rf_waddr}, {27'd0, e.waddr});
            chk({tag, ".wdata"}, ms_to_ws_rf_wdata,          e.wdata);
            chk({tag, ".fwd"},   ms_rf_wdata,                e.wdata);
        end
    endtask

    // Load through REQ (addr_ok after dly cycles) and WAIT (data_ok next cycle) to DONE.
    task automatic run_load(input string tag, input logic [31:0] pc, input logic [31:0] addr,
                            input logic [2:0] lop, input logic [31:0] rd,
                            input logic [31:0] exp_wd, input int dly, input logic expect_wb);
        drive(pc, 1'b1, 4'h0, addr, 32'h0, lop, 4'hF, 5'd7, 32'h5555_AAAA);
        if (expect_wb) push(pc, 4'hF, 5'd7, exp_wd);
        tick();
        es_to_ms_valid = 1'b0;
        for (int i = 0; i <= dly; i++) begin
            chk({tag, ".req"},     {31'd0, data_sram_req},   32'd1);
            chk({tag, ".addr"},    data_sram_addr,           addr);
            chk({tag, ".wstrb"},   {28'd0, data_sram_wstrb}, 32'd0);
            chk({tag, ".pending"}, {31'd0, ms_load_pending}, 32'd1);
            chk({tag, ".allow"},   {31'd0, ms_allow_in},     32'd0);
            if (i == dly) data_sram_addr_ok = 1'b1;
            tick();
        end
        data_sram_addr_ok = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = rd;
        chk({tag, ".wait_req"},   {31'd0, data_sram_req},  32'd0);
        chk({tag, ".wait_valid"}, {31'd0, ms_to_ws_valid}, 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        es_to_ms_valid = 1'b0; es_pc = 32'h0; es_mem_en = 1'b0; es_mem_we = 4'h0;
        es_mem_addr = 32'h0; es_mem_wdata = 32'h0; es_load_op = 3'd0;
        es_rf_we = 4'h0; es_rf_waddr = 5'd0; es_rf_wdata = 32'h0;
        data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0; data_sram_rdata = 32'h0;
        ws_allow_in = 1'b1;
        tick(); tick();
        reset = 1'b0;
        chk("rst.valid", {31'd0, ms_to_ws_valid}, 32'd0);
        chk("rst.req",   {31'd0, data_sram_req},  32'd0);
        chk("rst.allow", {31'd0, ms_allow_in},    32'd1);
        chk("rst.pc",    ms_pc_out,               32'h1c00_0000);
        chk("rst.rfwe",  {28'd0, ms_rf_we},       32'd0);

        // Plain ALU op: one cycle in the stage, no memory request.
        drive(32'h1c00_0004, 1'b0, 4'h0, 32'h0, 32'h0, 3'd0, 4'hF, 5'd5, 32'h1234_5678);
        push(32'h1c00_0004, 4'hF, 5'd5, 32'h1234_5678);
        tick();
        es_to_ms_valid = 1'b0;
        chk("alu.req",  {31'd0, data_sram_req}, 32'd0);
        chk("alu.rfwe", {28'd0, ms_rf_we},      32'hF);
        sb_check("alu");
        tick();
        chk("alu.drain", {31'd0, ms_to_ws_valid}, 32'd0);

        // Loads of each width/sign; the read data bus is scrubbed after data_ok.
        run_load("ldb",  32'h1c00_0008, 32'h1000_0003, 3'd1, 32'h80FF_0000, 32'hFFFF_FF80, 0, 1'b1);
        tick(); data_sram_data_ok = 1'b0; data_sram_rdata = 32'h0;
        chk("ldb.pending", {31'd0, ms_load_pending}, 32'd0);
        sb_check("ldb");
        tick();
        run_load("ldbu", 32'h1c00_000c, 32'h1000_0003, 3'd4, 32'h80FF_0000, 32'h0000_0080, 0, 1'b1);
        tick(); data_sram_data_ok = 1'b0; data_sram_rdata = 32'h0;
        sb_check("ldbu");
        tick();
        run_load("ldh",  32'h1c00_0010, 32'h1000_0002, 3'd2, 32'h80FF_0000, 32'hFFFF_80FF, 0, 1'b1);
        tick(); data_sram_data_ok = 1'b0; data_sram_rdata = 32'h0;
        sb_check("ldh");
        tick();
        run_load("ldhu", 32'h1c00_0014, 32'h1000_0000, 3'd5, 32'h1234_8123, 32'h0000_8123, 0, 1'b1);
        tick(); data_sram_data_ok = 1'b0; data_sram_rdata = 32'h0;
        sb_check("ldhu");
        tick();

        // addr_ok withheld four cycles.
        run_load("ldw_slow", 32'h1c00_0018, 32'h1000_0104, 3'd3, 32'hA5A5_0F0F, 32'hA5A5_0F0F, 4, 1'b1);
        tick(); data_sram_data_ok = 1'b0; data_sram_rdata = 32'h0;
        sb_check("ldw_slow");
        tick();

        // Store: waits for data_ok, no register write.
        drive(32'h1c00_001c, 1'b1, 4'hF, 32'h2000_0000, 32'hDEAD_BEEF, 3'd0, 4'h0, 5'd0, 32'h0);
        push(32'h1c00_001c, 4'h0, 5'd0, 32'h0);
        tick();
        es_to_ms_valid = 1'b0;
        chk("st.req",   {31'd0, data_sram_req},   32'd1);
        chk("st.wr",    {31'd0, data_sram_wr},    32'd1);
        chk("st.wstrb", {28'd0, data_sram_wstrb}, 32'hF);
        chk("st.wdata", data_sram_wdata,          32'hDEAD_BEEF);
        chk("st.rfwe",  {28'd0, ms_rf_we},        32'd0);
        data_sram_addr_ok = 1'b1;
        tick();
        data_sram_addr_ok = 1'b0;
        chk("st.wait0", {31'd0, ms_to_ws_valid}, 32'd0);
        tick();
        chk("st.wait1", {31'd0, ms_to_ws_valid}, 32'd0);
        data_sram_data_ok = 1'b1;
        tick();
        data_sram_data_ok = 1'b0;
        sb_check("st");
        tick();

        // Back-pressure in DONE with a new instruction waiting upstream.
        ws_allow_in = 1'b0;
        run_load("bp", 32'h1c00_0020, 32'h1000_0200, 3'd3, 32'hCAFE_F00D, 32'hCAFE_F00D, 0, 1'b1);
        tick(); data_sram_data_ok = 1'b0;
        drive(32'h1c00_0024, 1'b0, 4'h0, 32'h0, 32'h0, 3'd0, 4'h3, 5'd9, 32'h0BAD_F00D);
        push(32'h1c00_0024, 4'h3, 5'd9, 32'h0BAD_F00D);
        for (int i = 0; i < 3; i++) begin
            data_sram_rdata = 32'h1111_1111 * (i + 1);
            chk("bp.valid", {31'd0, ms_to_ws_valid}, 32'd1);
            chk("bp.allow", {31'd0, ms_allow_in},    32'd0);
            chk("bp.req",   {31'd0, data_sram_req},  32'd0);
            chk("bp.pc",    ms_pc_out,               32'h1c00_0020);
            chk("bp.wdata", ms_to_ws_rf_wdata,       32'hCAFE_F00D);
            tick();
        end
        ws_allow_in = 1'b1;
        #1;
        chk("bp.allow_rise", {31'd0, ms_allow_in}, 32'd1);
        sb_check("bp");
        tick();
        es_to_ms_valid = 1'b0;
        sb_check("bp_next");
        tick();

        // Reset during REQ drops the request immediately.
        drive(32'h1c00_0028, 1'b1, 4'h0, 32'h1000_0300, 32'h0, 3'd3, 4'hF, 5'd7, 32'h0);
        tick();
        es_to_ms_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("rstreq.req", {31'd0, data_sram_req}, 32'd0);
        tick();
        reset = 1'b0;

        // Reset while waiting for data; a concurrent data_ok must be ignored.
        run_load("rstw", 32'h1c00_002c, 32'h1000_0400, 3'd3, 32'h7777_7777, 32'h0, 0, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        data_sram_data_ok = 1'b0;
        chk("rstw.valid",   {31'd0, ms_to_ws_valid},  32'd0);
        chk("rstw.allow",   {31'd0, ms_allow_in},     32'd1);
        chk("rstw.req",     {31'd0, data_sram_req},   32'd0);
        chk("rstw.pc",      ms_pc_out,                32'h1c00_0000);
        chk("rstw.pending", {31'd0, ms_load_pending}, 32'd0);
        tick();
        chk("rstw.stay", {31'd0, ms_to_ws_valid}, 32'd0);
        chk("sb.leftover", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
